axi_fc_layer_engine: RTL

Parametrised fully-connected layer engine, successor to the single-stream FC controller.
- Accepts an activation vector over AXI4-S slave and buffers it.
- Computes OUT_LEN signed dot products against weights and bias read from an external synchronous memory, one MAC per cycle.
- Emits the quantised results over AXI4-S master; sits between the last conv/pool stage and the classifier output DMA.

---
 rtl/fc_pkg.sv | 39 +++
 rtl/fc_mac_unit.sv | 61 ++++++
 rtl/axi_fc_layer_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_pkg
// Desc   : State encoding and arithmetic helpers shared by the FC layer engine.
// Rev    : 1.0
// ============================================================================
package fc_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_MAC   = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4
  } fc_state_t;

  // Each neuron owns IN_LEN consecutive weights followed by its bias.
  function automatic int fc_stride(input int in_len);
    return in_len + 1;
  endfunction

  function automatic logic signed [63:0] fc_shift_sat(
    input logic signed [63:0] val,
    input int                 frac,
    input int                 data_w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = val >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// ============================================================================
// Module : fc_mac_unit
// Desc   : Signed MAC with bias add, shift and saturation; FC_RELU_EN clamps
//          negative results to zero.
// Rev    : 1.0
// ============================================================================
module fc_mac_unit #(
  parameter int DATA_W    = 16,
  parameter int WGT_W     = 16,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc_en,
  input  logic                     fin_en,
  input  logic signed [DATA_W-1:0] act,
  input  logic signed [WGT_W-1:0]  wgt,
  output logic signed [DATA_W-1:0] result
);
  import fc_pkg::*;

  localparam int PW = DATA_W + WGT_W;

  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_res;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = act * wgt;
  assign w_prod_ext = ACC_W'(w_prod);
  // Bias is aligned to the product's fixed point before the common shift.
  assign w_bias_ext = ACC_W'(wgt) <<< FRAC_BITS;
  assign w_sum      = r_acc + w_bias_ext;
  assign w_sat      = DATA_W'(fc_shift_sat(64'(w_sum), FRAC_BITS, DATA_W));

  always_comb begin
    w_res = w_sat;
`ifdef FC_RELU_EN
    if (w_sat[DATA_W-1]) w_res = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      result <= '0;
    end else if (fin_en) begin
      result <= w_res;
      r_acc  <= '0;
    end else if (acc_en) begin
      r_acc  <= r_acc + w_prod_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module : axi_fc_layer_engine
// Desc   : AXI4-S fully-connected layer: buffers a vector, runs one MAC per
//          cycle against external weights, streams quantised results.
//          Optional macro: FC_RELU_EN (ReLU on results).
// Rev    : 1.0
// ============================================================================
module axi_fc_layer_engine #(
  parameter int AXI_BUS_WIDTH = 32,
  parameter int DATA_W        = 16,
  parameter int WGT_W         = 16,
  parameter int ACC_W         = 40,
  parameter int FRAC_BITS     = 8,
  parameter int IN_LEN        = 64,
  parameter int OUT_LEN       = 10,
  parameter int WADDR_W       = 10
) (
  input  logic                       axi_clk,
  input  logic                       axi_reset_n,
  input  logic                       s_axis_valid,
  input  logic [AXI_BUS_WIDTH-1:0]   s_axis_data,
  output logic                       s_axis_ready,
  input  logic                       s_axis_last,
  input  logic [AXI_BUS_WIDTH/8-1:0] s_axis_keep,
  output logic                       m_axis_valid,
  output logic [AXI_BUS_WIDTH-1:0]   m_axis_data,
  input  logic                       m_axis_ready,
  output logic                       m_axis_last,
  output logic [AXI_BUS_WIDTH/8-1:0] m_axis_keep,
  output logic                       w_rd_en,
  output logic [WADDR_W-1:0]         w_addr,
  input  logic [WGT_W-1:0]           w_data,
  output logic                       busy,
  output logic                       err_short,
  output logic                       err_long
);
  import fc_pkg::*;

  localparam int STRIDE = fc_stride(IN_LEN);
  localparam int BW     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int IW     = $clog2(IN_LEN + 1);
  localparam int NW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int KW     = AXI_BUS_WIDTH / 8;

  fc_state_t                r_state;
  fc_state_t                w_next;
  logic [BW-1:0]            r_cnt;
  logic                     r_fill;
  logic                     r_live;
  logic                     r_acc_en;
  logic                     r_err_short;
  logic                     r_err_long;
  logic [IW-1:0]            r_idx;
  logic [NW-1:0]            r_neuron;
  logic [WADDR_W-1:0]       r_base;
  logic [WADDR_W-1:0]       r_addr_hold;
  logic signed [DATA_W-1:0] r_buf [IN_LEN];
  logic signed [DATA_W-1:0] r_act;
  logic signed [DATA_W-1:0] w_result;
  logic signed [DATA_W-1:0] w_buf_wd;
  logic                     w_beat;
  logic                     w_kept;
  logic                     w_cnt_last;
  logic                     w_idx_bias;
  logic                     w_neuron_last;
  logic                     w_buf_we;
  logic                     w_fin;

  assign w_beat        = s_axis_valid && s_axis_ready;
  assign w_kept        = w_beat && (s_axis_keep != '0);
  assign w_cnt_last    = (r_cnt == BW'(IN_LEN - 1));
  assign w_idx_bias    = (r_idx == IW'(IN_LEN));
  assign w_neuron_last = (r_neuron == NW'(OUT_LEN - 1));
  assign w_fin         = (r_state == ST_FINAL);

  // r_live keeps ready low while reset is asserted and for one cycle after.
  assign s_axis_ready = r_live && (((r_state == ST_LOAD) && !r_fill) || (r_state == ST_DRAIN));
  assign w_rd_en      = (r_state == ST_MAC);
  assign w_addr       = w_rd_en ? (r_base + WADDR_W'(r_idx)) : r_addr_hold;
  assign m_axis_valid = (r_state == ST_OUT);
  assign m_axis_last  = m_axis_valid && w_neuron_last;
  assign m_axis_keep  = {KW{m_axis_valid}};
  assign m_axis_data  = AXI_BUS_WIDTH'(w_result);
  assign busy         = !((r_state == ST_LOAD) && (r_cnt == '0) && !r_fill);
  assign err_short    = r_err_short;
  assign err_long     = r_err_long;

  assign w_buf_we = (r_state == ST_LOAD) && (r_fill || w_kept);
  assign w_buf_wd = r_fill ? '0 : s_axis_data[DATA_W-1:0];

  generate
    if (AXI_BUS_WIDTH > DATA_W) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^s_axis_data[AXI_BUS_WIDTH-1:DATA_W];
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (r_fill) begin
          if (w_cnt_last) w_next = ST_MAC;
        end else if (w_kept && w_cnt_last) begin
          w_next = s_axis_last ? ST_MAC : ST_DRAIN;
        end
      end
      ST_DRAIN: if (w_beat && s_axis_last) w_next = ST_MAC;
      ST_MAC:   if (w_idx_bias) w_next = ST_FINAL;
      ST_FINAL: w_next = ST_OUT;
      ST_OUT:   if (m_axis_ready) w_next = w_neuron_last ? ST_LOAD : ST_MAC;
      default:  w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state     <= ST_LOAD;
      r_live      <= 1'b0;
      r_cnt       <= '0;
      r_fill      <= 1'b0;
      r_idx       <= '0;
      r_neuron    <= '0;
      r_base      <= '0;
      r_addr_hold <= '0;
      r_acc_en    <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_live   <= 1'b1;
      r_acc_en <= (r_state == ST_MAC) && !w_idx_bias;
      case (r_state)
        ST_LOAD: begin
          if (r_fill) begin
            if (w_cnt_last) begin
              r_fill   <= 1'b0;
              r_cnt    <= '0;
              r_base   <= '0;
              r_neuron <= '0;
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end else if (w_kept) begin
            if (w_cnt_last) begin
              r_cnt    <= '0;
              r_base   <= '0;
              r_neuron <= '0;
              if (!s_axis_last) r_err_long <= 1'b1;
            end else begin
              r_cnt <= r_cnt + BW'(1);
              if (s_axis_last) begin
                r_fill      <= 1'b1;
                r_err_short <= 1'b1;
              end
            end
          end
        end
        ST_MAC: begin
          r_addr_hold <= w_addr;
          r_idx       <= w_idx_bias ? '0 : r_idx + IW'(1);
        end
        ST_OUT: begin
          if (m_axis_ready && !w_neuron_last) begin
            r_neuron <= r_neuron + NW'(1);
            r_base   <= r_base + WADDR_W'(STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge axi_clk) begin
    if (w_buf_we) r_buf[r_cnt] <= w_buf_wd;
    r_act <= r_buf[r_idx[BW-1:0]];
  end

  fc_mac_unit #(
    .DATA_W    (DATA_W),
    .WGT_W     (WGT_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk    (axi_clk),
    .rst_n  (axi_reset_n),
    .acc_en (r_acc_en),
    .fin_en (w_fin),
    .act    (r_act),
    .wgt    (w_data),
    .result (w_result)
  );

endmodule
`default_nettype wire
